// File: rtl/key_event_decoder_pkg.sv
// Shared state encodings, default timing constants and constant helpers
// for the key event decoder and other key-consuming blocks.
package key_event_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  localparam int LONG_MS_DEF   = 1000;
  localparam int DCLICK_MS_DEF = 300;
  localparam int REPEAT_MS_DEF = 200;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the previous "pressed" sample and flags press/release edges.
// Reusable by any block that consumes the debounced key level.
module key_edge_detect (
  input  logic clk_1KHz,
  input  logic rst,
  input  logic act,
  output logic pe,
  output logic re
);

  logic key_d;

  always_ff @(posedge clk_1KHz or posedge rst) begin
    if (rst) key_d <= 1'b0;
    else     key_d <= act;
  end

  // key_d resets inactive so a key held through reset yields a press edge
  assign pe = act & ~key_d;
  assign re = ~act & key_d;

endmodule

// File: rtl/key_event_decoder.sv
// Turns the debounced key level into one-cycle event pulses
// (press, release, short, long, double, repeat) plus an event counter.
//
// state          | meaning
// IDLE           | key released, nothing pending
// PRESSED        | first press, timing toward long press
// LONG_HELD      | long press reached, auto-repeat running
// WAIT_SECOND    | released after short press, waiting for a second press
// SECOND_PRESSED | second press of a double click, waiting for release
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter logic ACTIVE_LEVEL = 1'b1,
  parameter int   LONG_MS      = LONG_MS_DEF,
  parameter int   DCLICK_MS    = DCLICK_MS_DEF,
  parameter int   REPEAT_MS    = REPEAT_MS_DEF
) (
  input  logic       clk_1KHz,
  input  logic       rst,
  input  logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       double_pulse,
  output logic       repeat_pulse,
  output logic       holding,
  output logic [7:0] event_cnt
);

  localparam int TW = clog2(max3(LONG_MS, DCLICK_MS, REPEAT_MS)) + 1;
  localparam logic [TW-1:0] TMAX       = '1;
  localparam logic [TW-1:0] LONG_TC    = TW'(LONG_MS - 1);
  localparam logic [TW-1:0] DCLICK_TC  = TW'(DCLICK_MS - 1);
  localparam logic [TW-1:0] REPEAT_TC  = TW'(REPEAT_MS - 1);

  logic act;
  logic pe;
  logic re;

  state_t          state;
  logic [TW-1:0]   timer;

  assign act = (key_level == ACTIVE_LEVEL);

  key_edge_detect u_edge (
    .clk_1KHz (clk_1KHz),
    .rst      (rst),
    .act      (act),
    .pe       (pe),
    .re       (re)
  );

  always_ff @(posedge clk_1KHz or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      double_pulse  <= 1'b0;
      repeat_pulse  <= 1'b0;
      holding       <= 1'b0;
      event_cnt     <= 8'd0;
    end else begin
      press_pulse   <= pe;
      release_pulse <= re;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      double_pulse  <= 1'b0;
      repeat_pulse  <= 1'b0;
      holding       <= 1'b0;
      // transitions below override this with a clear
      timer         <= (timer == TMAX) ? timer : timer + 1'b1;

      case (state)
        IDLE: begin
          if (pe) begin
            state <= PRESSED;
            timer <= '0;
          end
        end
        PRESSED: begin
          if (re) begin
            state <= WAIT_SECOND;
            timer <= '0;
          end else if (timer == LONG_TC) begin
            state      <= LONG_HELD;
            timer      <= '0;
            long_pulse <= 1'b1;
            holding    <= 1'b1;
            event_cnt  <= event_cnt + 8'd1;
          end
        end
        LONG_HELD: begin
          if (re) begin
            state <= IDLE;
            timer <= '0;
          end else begin
            holding <= 1'b1;
            if (timer == REPEAT_TC) begin
              repeat_pulse <= 1'b1;
              timer        <= '0;
            end
          end
        end
        WAIT_SECOND: begin
          if (pe) begin
            state <= SECOND_PRESSED;
            timer <= '0;
          end else if (timer == DCLICK_TC) begin
            state       <= IDLE;
            timer       <= '0;
            short_pulse <= 1'b1;
            event_cnt   <= event_cnt + 8'd1;
          end
        end
        SECOND_PRESSED: begin
          if (re) begin
            state        <= IDLE;
            timer        <= '0;
            double_pulse <= 1'b1;
            event_cnt    <= event_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
